// File: rtl/pipe_pkg.sv
// Purpose: constants and types shared by the MIPS pipeline-register slice.
// Provides: reset/exception PCs, exception-code width and the "no exception" code.
// Also provides: the stage identifiers for naming register instances (F/D, D/E, E/M, M/W).
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam int          EC_W     = 5;
  localparam logic [EC_W-1:0] EXC_NONE = '0;

  // Pipeline stages; a register instance sits between two consecutive stages.
  typedef enum logic [2:0] {
    STG_F = 3'd0,
    STG_D = 3'd1,
    STG_E = 3'd2,
    STG_M = 3'd3,
    STG_W = 3'd4
  } pipe_stage_e;

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle after it is presented.
// Ports: clk, reset (sync, active-high, clears to 0), inc (count enable), count (current value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose: inter-stage pipeline register with CP0 redirect, flush and stall handling.
// Latency: 1 cycle, every output straight from a flop; stall holds or injects a bubble per BUBBLE_ON_STALL.
// Ports: clk/reset (sync, active-high); int_req/eret/epc/flush/stall control; in_* payload in,
//        out_* registered payload; stall_cnt/bubble_cnt saturating event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W          = 32,
  parameter int                 NUM_FIELDS      = 5,
  parameter int                 EC_W            = pipe_pkg::EC_W,
  parameter int                 CNT_W           = 16,
  parameter bit                 BUBBLE_ON_STALL = 1'b0,
  parameter logic [DATA_W-1:0]  RESET_PC        = pipe_pkg::RESET_PC,
  parameter logic [DATA_W-1:0]  EXC_PC          = pipe_pkg::EXC_PC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         int_req,
  input  logic                         eret,
  input  logic [DATA_W-1:0]            epc,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic [EC_W-1:0]              in_exc,
  input  logic                         in_bd,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_instr,
  output logic [DATA_W-1:0]            out_pc,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [EC_W-1:0]              out_exc,
  output logic                         out_bd,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             bubble_cnt
);

  // One-hot event select, index order is priority order (reset handled in the flop block).
  localparam int SEL_INT   = 0;
  localparam int SEL_ERET  = 1;
  localparam int SEL_FLUSH = 2;
  localparam int SEL_STALL = 3;
  localparam int SEL_LOAD  = 4;

  logic [4:0] sel;

  logic                         valid_q, valid_d;
  logic [DATA_W-1:0]            instr_q, instr_d;
  logic [DATA_W-1:0]            pc_q,    pc_d;
  logic [NUM_FIELDS*DATA_W-1:0] data_q,  data_d;
  logic [EC_W-1:0]              exc_q,   exc_d;
  logic                         bd_q,    bd_d;

  logic stall_inc;
  logic bubble_inc;

  always_comb begin
    sel = '0;
    if (int_req) begin
      sel[SEL_INT] = 1'b1;
    end else if (eret) begin
      sel[SEL_ERET] = 1'b1;
    end else if (flush) begin
      sel[SEL_FLUSH] = 1'b1;
    end else if (stall) begin
      sel[SEL_STALL] = 1'b1;
    end else begin
      sel[SEL_LOAD] = 1'b1;
    end
  end

  always_comb begin
    // Default is hold, which is exactly the non-bubbling stall response.
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    data_d  = data_q;
    exc_d   = exc_q;
    bd_d    = bd_q;

    if (sel[SEL_LOAD]) begin
      // An empty slot still carries PC/BD so CP0 can report a sane EPC.
      valid_d = in_valid;
      pc_d    = in_pc;
      bd_d    = in_bd;
      instr_d = in_valid ? in_instr : '0;
      data_d  = in_valid ? in_data  : '0;
      exc_d   = in_valid ? in_exc   : EC_W'(EXC_NONE);
    end else if (!sel[SEL_STALL] || BUBBLE_ON_STALL) begin
      valid_d = 1'b0;
      instr_d = '0;
      data_d  = '0;
      exc_d   = EC_W'(EXC_NONE);
      bd_d    = 1'b0;
      if (sel[SEL_INT]) begin
        pc_d = EXC_PC;
      end else if (sel[SEL_ERET]) begin
        pc_d = epc;
      end else if (sel[SEL_FLUSH]) begin
        pc_d = in_pc;
      end else begin
        // Stall bubble keeps the incoming PC and delay-slot flag for EPC.
        pc_d = in_pc;
        bd_d = in_bd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      exc_q   <= EC_W'(EXC_NONE);
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign stall_inc  = sel[SEL_STALL];
  assign bubble_inc = sel[SEL_INT] | sel[SEL_ERET] | sel[SEL_FLUSH] |
                      (sel[SEL_STALL] & BUBBLE_ON_STALL);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;
  assign out_data  = data_q;
  assign out_exc   = exc_q;
  assign out_bd    = bd_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: directed bench for pipe_stage_reg with hold-on-stall, bubble-on-stall and 2-bit-counter instances.
// Latency: each step drives inputs, waits one posedge, samples 1 time unit later.
// Ports: all three instances share the same stimulus; each has its own outputs.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int NF = 5;
  localparam int EW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, int_req, eret, flush, stall, in_valid, in_bd;
  logic [DW-1:0]  epc, in_instr, in_pc;
  logic [NF*DW-1:0] in_data;
  logic [EW-1:0]  in_exc;

  // u0: hold on stall, 16-bit counters
  logic           o0_valid, o0_bd;
  logic [DW-1:0]  o0_instr, o0_pc;
  logic [NF*DW-1:0] o0_data;
  logic [EW-1:0]  o0_exc;
  logic [15:0]    o0_scnt, o0_bcnt;
  // u1: bubble on stall
  logic           o1_valid, o1_bd;
  logic [DW-1:0]  o1_instr, o1_pc;
  logic [NF*DW-1:0] o1_data;
  logic [EW-1:0]  o1_exc;
  logic [15:0]    o1_scnt, o1_bcnt;
  // u2: hold on stall, 2-bit counters
  logic           o2_valid, o2_bd;
  logic [DW-1:0]  o2_instr, o2_pc;
  logic [NF*DW-1:0] o2_data;
  logic [EW-1:0]  o2_exc;
  logic [1:0]     o2_scnt, o2_bcnt;

  pipe_stage_reg #(.BUBBLE_ON_STALL(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .int_req(int_req), .eret(eret), .epc(epc), .flush(flush),
    .stall(stall), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
    .in_exc(in_exc), .in_bd(in_bd), .out_valid(o0_valid), .out_instr(o0_instr), .out_pc(o0_pc),
    .out_data(o0_data), .out_exc(o0_exc), .out_bd(o0_bd), .stall_cnt(o0_scnt), .bubble_cnt(o0_bcnt));

  pipe_stage_reg #(.BUBBLE_ON_STALL(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .int_req(int_req), .eret(eret), .epc(epc), .flush(flush),
    .stall(stall), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
    .in_exc(in_exc), .in_bd(in_bd), .out_valid(o1_valid), .out_instr(o1_instr), .out_pc(o1_pc),
    .out_data(o1_data), .out_exc(o1_exc), .out_bd(o1_bd), .stall_cnt(o1_scnt), .bubble_cnt(o1_bcnt));

  pipe_stage_reg #(.BUBBLE_ON_STALL(1'b0), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .int_req(int_req), .eret(eret), .epc(epc), .flush(flush),
    .stall(stall), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
    .in_exc(in_exc), .in_bd(in_bd), .out_valid(o2_valid), .out_instr(o2_instr), .out_pc(o2_pc),
    .out_data(o2_data), .out_exc(o2_exc), .out_bd(o2_bd), .stall_cnt(o2_scnt), .bubble_cnt(o2_bcnt));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [NF*DW-1:0] obs, input logic [NF*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    reset = 1'b0; int_req = 1'b0; eret = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  logic [NF*DW-1:0] data_a;
  logic [NF*DW-1:0] data_b;

  initial begin
    data_a = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    data_b = {32'hAAAA_000A, 32'hBBBB_000B, 32'hCCCC_000C, 32'hDDDD_000D, 32'hEEEE_000E};
    clr_ctl();
    reset = 1'b1; epc = '0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    in_data = '0; in_exc = '0; in_bd = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_pc",    o0_pc,    32'h0000_3000);
    check("rst_valid", o0_valid, 1'b0);
    check("rst_scnt",  o0_scnt,  16'd0);
    check("rst_bcnt",  o0_bcnt,  16'd0);
    check("rst_instr", o0_instr, 32'h0);

    // Plain load
    clr_ctl();
    in_valid = 1'b1; in_pc = 32'h3004; in_instr = 32'h2408_0001; in_data = data_a;
    tick();
    check("ld_pc",    o0_pc,    32'h3004);
    check("ld_instr", o0_instr, 32'h2408_0001);
    check("ld_valid", o0_valid, 1'b1);
    check("ld_data",  o0_data,  data_a);

    // Three stalls with changing inputs
    stall = 1'b1; in_pc = 32'h3008; in_instr = 32'h1111_1111; in_data = data_b;
    tick();
    in_pc = 32'h300C; in_instr = 32'h2222_2222;
    tick();
    in_pc = 32'h3010; in_instr = 32'h3333_3333; in_bd = 1'b1;
    tick();
    check("hold_pc",    o0_pc,    32'h3004);
    check("hold_instr", o0_instr, 32'h2408_0001);
    check("hold_valid", o0_valid, 1'b1);
    check("hold_data",  o0_data,  data_a);
    check("hold_scnt",  o0_scnt,  16'd3);
    check("hold_bcnt",  o0_bcnt,  16'd0);
    check("bub_valid",  o1_valid, 1'b0);
    check("bub_instr",  o1_instr, 32'h0);
    check("bub_pc",     o1_pc,    32'h3010);
    check("bub_bd",     o1_bd,    1'b1);
    check("bub_bcnt",   o1_bcnt,  16'd3);
    check("sat3_scnt",  o2_scnt,  2'd3);

    // Two more stalls: 2-bit counter must stick at 3
    tick(); tick();
    check("hold5_scnt", o0_scnt, 16'd5);
    check("sat5_scnt",  o2_scnt, 2'd3);
    check("bub5_bcnt",  o1_bcnt, 16'd5);

    // Load of an empty slot: payload zeroed, PC/BD kept
    clr_ctl();
    in_valid = 1'b0; in_instr = 32'hDEAD_BEEF; in_pc = 32'h3014; in_bd = 1'b1; in_exc = 5'd7;
    tick();
    check("inv_valid", o0_valid, 1'b0);
    check("inv_instr", o0_instr, 32'h0);
    check("inv_pc",    o0_pc,    32'h3014);
    check("inv_bd",    o0_bd,    1'b1);
    check("inv_exc",   o0_exc,   5'd0);
    check("inv_data",  o0_data,  '0);

    // Exception code passes through untouched
    in_valid = 1'b1; in_pc = 32'h3018; in_bd = 1'b0; in_exc = 5'd12; in_instr = 32'h0000_000C;
    tick();
    check("exc_pass", o0_exc,   5'd12);
    check("exc_pc",   o0_pc,    32'h3018);

    // All events at once: interrupt wins
    int_req = 1'b1; eret = 1'b1; flush = 1'b1; stall = 1'b1;
    epc = 32'h3020; in_pc = 32'h3040; in_bd = 1'b1;
    tick();
    check("int_pc",    o0_pc,    32'h4180);
    check("int_bd",    o0_bd,    1'b0);
    check("int_valid", o0_valid, 1'b0);
    check("int_exc",   o0_exc,   5'd0);
    check("int_bcnt",  o0_bcnt,  16'd1);
    check("int_scnt",  o0_scnt,  16'd5);
    check("int_bcnt1", o1_bcnt,  16'd6);
    check("int_scnt1", o1_scnt,  16'd5);

    // ERET beats flush
    clr_ctl();
    eret = 1'b1; flush = 1'b1; epc = 32'h3020; in_pc = 32'h3050;
    tick();
    check("eret_pc",   o0_pc,   32'h3020);
    check("eret_bd",   o0_bd,   1'b0);
    check("eret_bcnt", o0_bcnt, 16'd2);

    // Flush beats stall
    clr_ctl();
    flush = 1'b1; stall = 1'b1; in_pc = 32'h3060; in_bd = 1'b1;
    tick();
    check("fl_pc",    o0_pc,    32'h3060);
    check("fl_bd",    o0_bd,    1'b0);
    check("fl_valid", o0_valid, 1'b0);
    check("fl_bcnt",  o0_bcnt,  16'd3);
    check("fl_scnt",  o0_scnt,  16'd5);

    // Reset during a stall
    clr_ctl();
    reset = 1'b1; stall = 1'b1;
    tick();
    check("rs_pc",    o0_pc,   32'h3000);
    check("rs_scnt",  o0_scnt, 16'd0);
    check("rs_bcnt",  o0_bcnt, 16'd0);
    check("rs_scnt2", o2_scnt, 2'd0);

    reset = 1'b0; in_pc = 32'h3070; in_bd = 1'b1; in_valid = 1'b1;
    tick();
    check("rs_hold_pc",  o0_pc,    32'h3000);
    check("rs_hold_vld", o0_valid, 1'b0);
    check("rs_hold_sc",  o0_scnt,  16'd1);
    check("rs_bub_pc",   o1_pc,    32'h3070);
    check("rs_bub_bd",   o1_bd,    1'b1);
    check("rs_bub_bc",   o1_bcnt,  16'd1);

    // Resume loading
    clr_ctl();
    in_pc = 32'h3074; in_instr = 32'h2409_0002; in_bd = 1'b0; in_exc = 5'd0;
    tick();
    check("res_pc",    o0_pc,    32'h3074);
    check("res_instr", o0_instr, 32'h2409_0002);
    check("res_valid", o0_valid, 1'b1);
    check("res_scnt",  o0_scnt,  16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
